// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and helpers for decoder_fn_stage
package decoder_pkg;
    localparam int MAX_N = 256;
    localparam logic [15:0] MASK0_RST = 16'hFC0C;
    localparam logic [15:0] MASK1_RST = 16'hDDD0;

    function automatic logic [MAX_N-1:0] onehot_of(input logic [7:0] sel);
        return {{(MAX_N-1){1'b0}}, 1'b1} << sel;
    endfunction
endpackage

// File: rtl/decoder_fn_stage_sat_counter.sv
// sat_counter: saturating hit counter with synchronous clear that beats increment
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= cnt_d;

    assign cnt = cnt_q;
endmodule

// File: rtl/decoder_fn_stage.sv
// decoder_fn_stage: registered one-hot decoder with programmable minterm functions
// and per-function saturating hit counters behind a valid/ready handshake.
module decoder_fn_stage
    import decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int NF    = 2,
    parameter int CNT_W = 8,
    localparam int N     = 1 << SEL_W,
    localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SEL_W-1:0]    in_sel,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        out_onehot,
    output logic [NF-1:0]       out_func,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [N-1:0]        cfg_mask,
    input  logic                cnt_clr,
    output logic [NF*CNT_W-1:0] hit_cnt
);
    typedef logic [N-1:0] mask_t;

    mask_t         oh, onehot_q, onehot_d;
    logic [NF-1:0] fn, func_q, func_d;
    logic          valid_q, valid_d, acc;

    assign in_ready = !valid_q || out_ready;
    assign acc      = in_valid && in_ready;
    assign oh       = mask_t'(onehot_of(8'(in_sel)));

    for (genvar i = 0; i < NF; i++) begin : g_fn
        localparam mask_t RST = (SEL_W == 4 && i == 0) ? mask_t'(MASK0_RST) :
                                (SEL_W == 4 && i == 1) ? mask_t'(MASK1_RST) : '0;
        mask_t mask_q;
        // fn sees the mask before any write landing on the same edge
        assign fn[i] = |(oh & mask_q);
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) mask_q <= RST;
            else if (cfg_we && cfg_idx == IDX_W'(i)) mask_q <= cfg_mask;
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (valid_q && out_ready && func_q[i]),
            .clr   (cnt_clr),
            .cnt   (hit_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_comb begin
        onehot_d = acc ? oh : onehot_q;
        func_d   = acc ? fn : func_q;
        valid_d  = acc || (valid_q && !out_ready);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid_q  <= 1'b0;
            onehot_q <= '0;
            func_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            onehot_q <= onehot_d;
            func_q   <= func_d;
        end

    assign out_valid  = valid_q;
    assign out_onehot = onehot_q;
    assign out_func   = func_q;
endmodule

// File: tb/tb_decoder_fn_stage.sv
// tb_decoder_fn_stage: directed + random checks of decoder_fn_stage against a
// behavioural model; three instances cover defaults, CNT_W=3 and SEL_W=3/NF=3.
module tb_decoder_fn_stage;
    logic        clk, rst_n;
    logic        in_valid, out_ready, cfg_we, cnt_clr;
    logic [3:0]  in_sel;
    logic [0:0]  cfg_idx;
    logic [15:0] cfg_mask;
    logic        in_ready, out_valid, b_in_ready, b_out_valid;
    logic [15:0] out_onehot, b_out_onehot, hit_cnt;
    logic [1:0]  out_func, b_out_func;
    logic [5:0]  b_hit_cnt;
    logic        c_in_valid, c_out_ready, c_cfg_we, c_cnt_clr, c_in_ready, c_out_valid;
    logic [2:0]  c_in_sel, c_out_func;
    logic [1:0]  c_cfg_idx;
    logic [7:0]  c_cfg_mask, c_out_onehot;
    logic [23:0] c_hit_cnt;

    int total = 0, bad = 0;
    bit mv, has;
    int msel;
    bit [1:0]  mf;
    bit [15:0] m [2];
    int ca [2], cb [2];

    decoder_fn_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot), .out_func(out_func),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt)
    );
    decoder_fn_stage #(.CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_sel(in_sel),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_onehot(b_out_onehot), .out_func(b_out_func),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_mask(cfg_mask), .cnt_clr(cnt_clr), .hit_cnt(b_hit_cnt)
    );
    decoder_fn_stage #(.SEL_W(3), .NF(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sel(c_in_sel),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_onehot(c_out_onehot), .out_func(c_out_func),
        .cfg_we(c_cfg_we), .cfg_idx(c_cfg_idx), .cfg_mask(c_cfg_mask), .cnt_clr(c_cnt_clr), .hit_cnt(c_hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0; has = 0; mf = 0; msel = 0;
        m[0] = 16'hFC0C; m[1] = 16'hDDD0;
        ca = '{0, 0}; cb = '{0, 0};
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, mv);
        chk("out_onehot", out_onehot, has ? 32'(1) << msel : 0);
        chk("out_func", out_func, has ? mf : 2'b00);
        chk("hit_cnt", hit_cnt, {8'(ca[1]), 8'(ca[0])});
        chk("b_out_valid", b_out_valid, mv);
        chk("b_out_onehot", b_out_onehot, has ? 32'(1) << msel : 0);
        chk("b_out_func", b_out_func, has ? mf : 2'b00);
        chk("b_hit_cnt", b_hit_cnt, {3'(cb[1]), 3'(cb[0])});
    endtask

    task automatic step(input bit v, input int sel, input bit rdy, input bit we = 0,
                        input bit idx = 0, input logic [15:0] mk = 0, input bit clr = 0);
        bit acc, dlv;
        @(negedge clk);
        in_valid = v; in_sel = 4'(sel); out_ready = rdy;
        cfg_we = we; cfg_idx = idx; cfg_mask = mk; cnt_clr = clr;
        #1;
        chk("in_ready", in_ready, !mv || rdy);
        chk("b_in_ready", b_in_ready, !mv || rdy);
        acc = v && (!mv || rdy);
        dlv = mv && rdy;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                ca[i] = 0; cb[i] = 0;
            end else if (dlv && mf[i]) begin
                ca[i] = (ca[i] < 255) ? ca[i] + 1 : 255;
                cb[i] = (cb[i] < 7) ? cb[i] + 1 : 7;
            end
        end
        if (acc) begin
            has = 1; mv = 1; msel = sel;
            for (int i = 0; i < 2; i++) mf[i] = m[i][sel];
        end else if (dlv) mv = 0;
        if (we) m[idx] = mk;
        @(posedge clk); #1;
        check_outputs();
    endtask

    task automatic cstep(input bit v, input int sel, input bit we, input int idx,
                         input logic [7:0] mk, input logic [2:0] ef);
        @(negedge clk);
        c_in_valid = v; c_in_sel = 3'(sel); c_cfg_we = we; c_cfg_idx = 2'(idx); c_cfg_mask = mk;
        @(posedge clk); #1;
        if (v) begin
            chk("c_out_valid", c_out_valid, 1);
            chk("c_out_onehot", c_out_onehot, 32'(1) << sel);
            chk("c_out_func", c_out_func, ef);
        end
    endtask

    initial begin
        rst_n = 0; in_valid = 0; in_sel = 0; out_ready = 0; cfg_we = 0; cfg_idx = 0;
        cfg_mask = 0; cnt_clr = 0;
        c_in_valid = 0; c_in_sel = 0; c_out_ready = 1; c_cfg_we = 0; c_cfg_idx = 0;
        c_cfg_mask = 0; c_cnt_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1;

        // default masks: decode stream 0..15
        for (int s = 0; s < 16; s++) begin
            step(1, s, 1);
            chk("set0", out_func[0], s inside {2, 3, [10:15]});
            chk("set1", out_func[1], s inside {4, 6, 7, 8, 10, 11, 12, 14, 15});
        end
        step(0, 0, 1);

        // back-pressure then bubble-free handoff
        step(1, 5, 1);
        repeat (3) begin
            step(0, 0, 0);
            chk("bp_onehot", out_onehot, 16'h0020);
        end
        step(1, 9, 1);
        chk("handoff", out_onehot, 16'h0200);

        // saturation at 7 and clear beating an increment
        step(0, 0, 1, 0, 0, 0, 1);
        repeat (10) step(1, 2, 1);
        step(0, 0, 1);
        chk("sat0", b_hit_cnt[2:0], 7);
        chk("sat1", b_hit_cnt[5:3], 0);
        step(1, 2, 1);
        step(1, 2, 1, 0, 0, 0, 1);
        chk("clr_wins", b_hit_cnt[2:0], 0);

        // config write racing an accept
        step(1, 0, 1, 1, 0, 16'h0001);
        chk("race_old", out_func[0], 0);
        step(1, 0, 1);
        chk("race_new", out_func[0], 1);

        // asynchronous reset while holding a result
        step(1, 3, 0);
        @(negedge clk);
        in_valid = 0; cfg_we = 0; cnt_clr = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        #1 rst_n = 1;
        step(1, 2, 1);
        chk("rst_mask0", out_func, 2'b01);
        step(1, 4, 1);
        chk("rst_mask1", out_func, 2'b10);

        repeat (300)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), 16'($urandom),
                 $urandom_range(0, 31) == 0);
        step(0, 0, 0);

        // SEL_W=3, NF=3 instance: masks reset to zero, out-of-range index ignored
        chk("c_in_ready", c_in_ready, 1);
        for (int s = 0; s < 8; s++) cstep(1, s, 0, 0, 0, 3'b000);
        cstep(0, 0, 1, 3, 8'hFF, 3'b000);
        for (int s = 0; s < 8; s++) cstep(1, s, 0, 0, 0, 3'b000);
        cstep(0, 0, 1, 2, 8'h10, 3'b000);
        cstep(1, 4, 0, 0, 0, 3'b100);
        cstep(1, 0, 1, 0, 8'h01, 3'b000);
        cstep(1, 0, 0, 0, 0, 3'b001);
        cstep(0, 0, 0, 0, 0, 3'b000);
        chk("c_hit_cnt", c_hit_cnt, 24'h010001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
